// File: rtl/fetch_pc_gen.sv
// Fetch stage: holds the architectural PC, fetches over a req/ack handshake and
// presents the instruction until retired. Optional macro: MISALIGN_TRAP_EN.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  next_pc_sel,
    input  logic [31:0] imm,
    input  logic [31:0] rf_rs1,
    input  logic        brch_taken,
    input  logic        inst_retire,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_encoding,
    output logic [31:0] pc,
    output logic        misalign_trap
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] w_target;
    logic [31:0] w_pc_nxt;
    logic        w_latch;
    logic        w_retire;

    assign w_retire = (r_state == HOLD) && inst_retire;

    always_comb begin
        w_target = r_pc + 32'd4;
        case (next_pc_sel)
            3'd1:    w_target = r_pc + imm;
            3'd2:    w_target = (rf_rs1 + imm) & ~32'h1;
            3'd3:    w_target = brch_taken ? (r_pc + imm) : (r_pc + 32'd4);
            default: w_target = r_pc + 32'd4;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign    = (w_target[1:0] != 2'b00);
    assign w_pc_nxt      = w_misalign ? TRAP_VEC : w_target;
    assign misalign_trap = w_retire && w_misalign && !rst;
`else
    assign w_pc_nxt      = w_target & ~32'h3;
    assign misalign_trap = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        case (r_state)
            FETCH: begin
                w_latch     = imem_ack;
                w_state_nxt = imem_ack ? HOLD : WAIT;
            end
            WAIT: begin
                w_latch = imem_ack;
                if (imem_ack) w_state_nxt = HOLD;
            end
            HOLD: begin
                if (inst_retire) w_state_nxt = FETCH;
            end
            default: w_state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_inst  <= NOP;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch)  r_inst <= imem_rdata;
            if (w_retire) r_pc   <= w_pc_nxt;
        end
    end

    // Request is gated by rst so a pending WAIT drops in the reset cycle itself.
    assign imem_req      = !rst && ((r_state == FETCH) || (r_state == WAIT));
    assign imem_addr     = r_pc;
    assign pc            = r_pc;
    assign inst_valid    = (r_state == HOLD);
    assign inst_encoding = r_inst;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: transaction-level model checked every cycle,
// directed literal checks, then randomized traffic. Honours MISALIGN_TRAP_EN.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  next_pc_sel;
    logic [31:0] imm;
    logic [31:0] rf_rs1;
    logic        brch_taken;
    logic        inst_retire;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_encoding;
    logic [31:0] pc;
    logic        misalign_trap;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: the stage either owns a fetched instruction or is still fetching one.
    logic [31:0] m_pc;
    logic        m_have;
    logic [31:0] m_enc;

    fetch_pc_gen #(
        .RESET_PC(32'h0000_0000),
        .TRAP_VEC(32'h0000_0100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .next_pc_sel  (next_pc_sel),
        .imm          (imm),
        .rf_rs1       (rf_rs1),
        .brch_taken   (brch_taken),
        .inst_retire  (inst_retire),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst_encoding(inst_encoding),
        .pc           (pc),
        .misalign_trap(misalign_trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] raw_target(input logic [2:0] sel, input logic [31:0] p,
                                               input logic [31:0] im, input logic [31:0] rs,
                                               input logic br);
        if (sel == 3'd1) return p + im;
        if (sel == 3'd2) return (rs + im) & 32'hFFFF_FFFE;
        if (sel == 3'd3 && br) return p + im;
        return p + 32'd4;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
        return t[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] loaded_pc(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
        return (t[1:0] != 2'b00) ? 32'h0000_0100 : t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    // One clock: compare all outputs at the falling edge, advance the model at the
    // rising edge, return 1 ns after it so the caller can drive the next inputs.
    task automatic step();
        logic [31:0] t;
        logic [31:0] n_pc;
        logic        n_have;
        logic [31:0] n_enc;
        @(negedge clk);
        t = raw_target(next_pc_sel, m_pc, imm, rf_rs1, brch_taken);
        chk("imem_req", {31'd0, imem_req}, {31'd0, !rst && !m_have});
        chk("imem_addr", imem_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_have});
        chk("inst_encoding", inst_encoding, m_enc);
        chk("misalign_trap", {31'd0, misalign_trap},
            {31'd0, !rst && m_have && inst_retire && is_misaligned(t)});
        n_pc = m_pc; n_have = m_have; n_enc = m_enc;
        if (rst) begin
            n_pc = 32'h0; n_have = 1'b0; n_enc = 32'h0000_0013;
        end else if (!m_have && imem_ack) begin
            n_have = 1'b1; n_enc = imem_rdata;
        end else if (m_have && inst_retire) begin
            n_have = 1'b0; n_pc = loaded_pc(t);
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_have = n_have; m_enc = n_enc;
    endtask

    task automatic idle_inputs();
        inst_retire = 1'b0;
        imem_ack    = 1'b0;
        next_pc_sel = 3'd0;
        imm         = 32'h0;
        rf_rs1      = 32'h0;
        brch_taken  = 1'b0;
    endtask

    task automatic goto_hold();
        int k;
        imem_ack    = 1'b1;
        inst_retire = 1'b0;
        imem_rdata  = $urandom;
        for (k = 0; k < 8 && !m_have; k++) step();
        chk("hold_reached", {31'd0, m_have}, 32'd1);
        imem_ack = 1'b0;
    endtask

    task automatic retire_to(input string name, input logic [2:0] sel, input logic [31:0] im,
                             input logic [31:0] rs, input logic br, input logic [31:0] exp_addr);
        goto_hold();
        next_pc_sel = sel; imm = im; rf_rs1 = rs; brch_taken = br;
        inst_retire = 1'b1;
        step();
        idle_inputs();
        chk(name, imem_addr, exp_addr);
    endtask

    initial begin
        rst = 1'b1;
        imem_rdata = 32'h0;
        idle_inputs();
        m_pc = 32'h0; m_have = 1'b0; m_enc = 32'h0000_0013;
        step();
        step();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_nop", inst_encoding, 32'h0000_0013);
        chk("rst_trap", {31'd0, misalign_trap}, 32'd0);

        // First fetch with ack tied high
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hCAFE_0001;
        #1;
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        step();
        chk("valid_after_ack", {31'd0, inst_valid}, 32'd1);
        chk("enc_after_ack", inst_encoding, 32'hCAFE_0001);
        imem_ack = 1'b0;
        retire_to("sel0_plus4", 3'd0, 32'h0, 32'h0, 1'b0, 32'h4);

        retire_to("to_100", 3'd1, 32'h0000_00FC, 32'h0, 1'b0, 32'h100);
        retire_to("jal_neg", 3'd1, 32'hFFFF_FFF0, 32'h0, 1'b0, 32'hF0);
        retire_to("to_100b", 3'd1, 32'h0000_0010, 32'h0, 1'b0, 32'h100);
        retire_to("br_not_taken", 3'd3, 32'h0000_0020, 32'h0, 1'b0, 32'h104);
        retire_to("to_100c", 3'd1, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h100);
        retire_to("br_taken", 3'd3, 32'h0000_0020, 32'h0, 1'b1, 32'h120);
        retire_to("jalr_lsb", 3'd2, 32'h0000_0004, 32'h2001, 1'b0, 32'h2004);
        retire_to("sel6_plus4", 3'd6, 32'h1234_5678, 32'h0, 1'b1, 32'h2008);
        retire_to("to_fffc", 3'd2, 32'h0, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC);
        retire_to("wrap", 3'd0, 32'h0, 32'h0, 1'b0, 32'h0);
        retire_to("to_100d", 3'd1, 32'h0000_0100, 32'h0, 1'b0, 32'h100);

        // Misaligned JAL target
        goto_hold();
        next_pc_sel = 3'd1; imm = 32'h2; inst_retire = 1'b1;
        #1;
`ifdef MISALIGN_TRAP_EN
        chk("trap_pulse", {31'd0, misalign_trap}, 32'd1);
`else
        chk("trap_pulse", {31'd0, misalign_trap}, 32'd0);
`endif
        step();
        idle_inputs();
        chk("misalign_addr", imem_addr, 32'h100);
        chk("trap_cleared", {31'd0, misalign_trap}, 32'd0);

        // Slow memory, then reset mid-wait with a colliding ack
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, 32'h100);
            chk("wait_valid", {31'd0, inst_valid}, 32'd0);
        end
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rst_drops_req", {31'd0, imem_req}, 32'd0);
        step();
        rst = 1'b0; imem_ack = 1'b0;
        #1;
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("post_rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("post_rst_enc", inst_encoding, 32'h0000_0013);

        // Reset wins over a simultaneous retire
        goto_hold();
        inst_retire = 1'b1; next_pc_sel = 3'd1; imm = 32'h40; rst = 1'b1;
        step();
        rst = 1'b0; idle_inputs();
        chk("rst_beats_retire", imem_addr, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 59) == 0);
            imem_ack    = ($urandom_range(0, 1) == 1);
            imem_rdata  = $urandom;
            inst_retire = ($urandom_range(0, 2) != 0);
            next_pc_sel = 3'($urandom_range(0, 7));
            imm         = ($urandom_range(0, 1) == 1) ? $urandom
                                                      : 32'($signed($urandom_range(0, 64)) - 32);
            rf_rs1      = $urandom;
            brch_taken  = ($urandom_range(0, 1) == 1);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
